mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port synchronous data/instruction memory between the CPU control path (port 0: fetch, load, store) and a secondary master (port 1: VGA frame-buffer reader or I/O DMA). Port 0 has fixed priority. A bounded-wait counter guarantees port 1 a slot. The block registers the winning request onto the memory bus and routes read data back with a per-port valid strobe. The CPU FSM uses `p0_gnt` as its advance condition and `p0_rvalid` as its load-writeback condition.

## Interface
- `ADDR_W`, default 16, memory address width
- `DATA_W`, default 16, memory data width
- `MAX_WAIT`, default 3, number of consecutive arbitrations port 1 may lose before it is forced to win (range 1..15)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `p0_req`  in  1  port 0 access request, held until `p0_gnt`
- `p0_we`  in  1  port 0 write (1) / read (0)
- `p0_addr`  in  `ADDR_W`  port 0 address
- `p0_wdata`  in  `DATA_W`  port 0 write data
- `p0_gnt`  out  1  port 0 request accepted (one-cycle pulse)
- `p0_rvalid`  out  1  port 0 read data valid
- `p0_rdata`  out  `DATA_W`  port 0 read data
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: same widths and meaning as port 0
- `mem_addr`  out  `ADDR_W`  registered memory address
- `mem_we`  out  1  registered memory write enable
- `mem_wdata`  out  `DATA_W`  registered memory write data
- `mem_rdata`  in  `DATA_W`  memory read data, valid one cycle after `mem_addr` is sampled

## Operation
- The design is a three-stage pipeline: ARB (combinational winner select), ISSUE (registered memory command, owner, is_read), RETURN (registered owner/valid of the read in flight).
- Winner select at each posedge:
  - Only one `req` high: that port wins.
  - Both high: port 0 wins, unless `wait_cnt == MAX_WAIT`, in which case port 1 wins.
  - Neither high: no issue.
- `wait_cnt` is 4 bits:
  - Increments (saturating at `MAX_WAIT`) when `p1_req` is high and port 1 loses.
  - Clears to 0 when port 1 wins or `p1_req` is low.
- On a win, the following are registered:
  - `mem_addr`, `mem_we`, `mem_wdata` from the winner.
  - The winner's `gnt` is set to 1 for exactly one cycle.
  - Owner and is_read (`!we`) are captured.
- No win: `mem_we` = 0, and `mem_addr`/`mem_wdata` hold their last value. Both `gnt` outputs are 0.
- RETURN: when the ISSUE stage held a read, the owner's `rvalid` goes to 1 the next cycle. A write produces no `rvalid`.
- `p0_rdata` and `p1_rdata` are both driven from `mem_rdata`. Their contents are meaningful only when the matching `rvalid` is high.
- Accesses are issued strictly in grant order. A write followed by a read of the same address (either port) returns the written data.
- Requester rule: a `req` still high during the cycle in which that port's `gnt` is high counts as a new request. This allows back-to-back access, one per cycle. A requester must update or drop `req`/`addr` in its `gnt` cycle.
- Reset:
  - `mem_addr`, `mem_wdata`, `mem_we`, both `gnt`, both `rvalid`, `wait_cnt`, and the ISSUE/RETURN valid bits all go to 0.
  - Requests present while `rst` is high are ignored.
- A read in flight when `rst` is asserted is discarded: it never produces `rvalid`, including the cycle after `rst` falls.

## Timing
- A request sampled at the posedge ending cycle N produces:
  - `gnt`, `mem_addr`, `mem_we`, `mem_wdata` during cycle N+1.
  - Memory samples at the posedge ending N+1.
  - `rvalid` with `rdata` during N+2.
- Read latency is 2 cycles from request to data. Write latency is 1 cycle to `mem_we`.
- Peak throughput is one access per cycle. Reads from both ports can be in flight back-to-back, with `rvalid` strobes following grant order.
- In the worst case, port 1 under continuous contention wins once every `MAX_WAIT`+1 cycles.
- The first request after `rst` deasserts can be granted in the following cycle.

## Test plan
- Reset: `rst` high for 2 cycles with `p0_req`=1 -> `gnt`/`rvalid`/`mem_we` all 0 throughout; `rst` low at cycle R -> `p0_gnt`=1 in R+1.
- Port 0 read of 0x0010, memory holding 0xBEEF -> `p0_gnt`=1 and `mem_addr`=0x0010 in N+1; `p0_rvalid`=1 with `p0_rdata`=0xBEEF in N+2; `p1_rvalid` stays 0.
- Port 1 write of 0x1234 to 0x0200, then port 1 read of 0x0200 -> `mem_we`=1 for one cycle; the read returns 0x1234 with `p1_rvalid`.
- Both ports requesting continuously, `MAX_WAIT`=3 -> grant sequence p0,p0,p0,p1,p0,p0,p0,p1; `wait_cnt` reaches 3 then clears.
- Simultaneous port 0 write of 0xAAAA and port 1 read, both to 0x0040, `wait_cnt`=0 -> port 0 is granted first, then port 1; `p1_rdata`=0xAAAA.
- `rst` asserted during N+1 of a port 0 read -> no `p0_rvalid` in N+2 or later; normal operation resumes after `rst` falls.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port fixed-priority memory arbiter with a bounded-wait guarantee for port 1.
// Pipeline: ARB (combinational select) -> ISSUE (registered command) -> RETURN (read owner/valid).
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: req is held until gnt; a req still high in its gnt cycle is a new request.
    // rvalid pulses for one cycle per read, in grant order; writes produce no rvalid.

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // ARB stage
    logic       force_p1;
    logic       win_p0;
    logic       win_p1;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // ISSUE stage
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              iss_rd_q, iss_rd_d;
    owner_e            iss_own_q, iss_own_d;

    // RETURN stage
    logic              ret_vld_q, ret_vld_d;
    owner_e            ret_own_q, ret_own_d;

    always_comb begin
        force_p1   = (wait_cnt_q == MAX_WAIT_C);
        win_p1     = p1_req && (!p0_req || force_p1);
        win_p0     = p0_req && !win_p1;

        // Counts consecutive lost arbitrations; any win or an idle port 1 resets it.
        wait_cnt_d = 4'd0;
        if (p1_req && !win_p1) begin
            wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + 4'd1 : MAX_WAIT_C;
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt0_d      = win_p0;
        gnt1_d      = win_p1;
        iss_rd_d    = 1'b0;
        iss_own_d   = iss_own_q;

        if (win_p1) begin
            mem_addr_d  = p1_addr;
            mem_wdata_d = p1_wdata;
            mem_we_d    = p1_we;
            iss_rd_d    = !p1_we;
            iss_own_d   = OWN_P1;
        end else if (win_p0) begin
            mem_addr_d  = p0_addr;
            mem_wdata_d = p0_wdata;
            mem_we_d    = p0_we;
            iss_rd_d    = !p0_we;
            iss_own_d   = OWN_P0;
        end

        ret_vld_d = iss_rd_q;
        ret_own_d = iss_own_q;
    end

    // Reset clears both valid stages, so a read in flight never returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q  <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            iss_rd_q    <= 1'b0;
            iss_own_q   <= OWN_P0;
            ret_vld_q   <= 1'b0;
            ret_own_q   <= OWN_P0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            iss_rd_q    <= iss_rd_d;
            iss_own_q   <= iss_own_d;
            ret_vld_q   <= ret_vld_d;
            ret_own_q   <= ret_own_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign p0_gnt    = gnt0_q;
    assign p1_gnt    = gnt1_q;
    assign p0_rvalid = ret_vld_q && (ret_own_q == OWN_P0);
    assign p1_rvalid = ret_vld_q && (ret_own_q == OWN_P1);
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic with resets,
// checked cycle by cycle against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 3;

    logic          clk;
    logic          rst;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous memory: write and registered read on posedge
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // expected per-cycle view of the DUT outputs
    typedef struct packed {
        logic          g0;
        logic          g1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rv0;
        logic          rv1;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic [DW-1:0] ref_mem [0:65535];
    int            p1_losses = 0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    logic          pend_rv0  = 1'b0;
    logic          pend_rv1  = 1'b0;
    logic [DW-1:0] pend_rdata = '0;
    int            last_win  = 0;   // 0 none, 1 port 0, 2 port 1

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected during the following cycle.
    task automatic step(input logic rs,
                        input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t e;
        int   win;
        @(negedge clk);
        rst = rs;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;

        e = '0;
        if (!rs) begin
            e.rv0 = pend_rv0; e.rv1 = pend_rv1; e.rdata = pend_rdata;
        end
        pend_rv0 = 1'b0;
        pend_rv1 = 1'b0;
        win = 0;
        if (rs) begin
            p1_losses = 0;
            m_addr    = '0;
            m_wdata   = '0;
        end else begin
            if (r0 && r1) win = (p1_losses == MW) ? 2 : 1;
            else if (r0)  win = 1;
            else if (r1)  win = 2;
            p1_losses = (r1 && win == 1) ? p1_losses + 1 : 0;
            if (win != 0) begin
                e.g0    = (win == 1);
                e.g1    = (win == 2);
                e.we    = (win == 1) ? w0 : w1;
                m_addr  = (win == 1) ? a0 : a1;
                m_wdata = (win == 1) ? d0 : d1;
                if (e.we) begin
                    ref_mem[m_addr] = m_wdata;
                end else begin
                    pend_rv0   = (win == 1);
                    pend_rv1   = (win == 2);
                    pend_rdata = ref_mem[m_addr];
                end
            end
        end
        e.addr  = m_addr;
        e.wdata = m_wdata;
        last_win = win;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rs);
        step(rs, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // scoreboard monitor
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("p0_gnt",    32'(p0_gnt),    32'(mon_e.g0));
            chk("p1_gnt",    32'(p1_gnt),    32'(mon_e.g1));
            chk("mem_we",    32'(mem_we),    32'(mon_e.we));
            chk("mem_addr",  32'(mem_addr),  32'(mon_e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
            chk("p0_rvalid", 32'(p0_rvalid), 32'(mon_e.rv0));
            chk("p1_rvalid", 32'(p1_rvalid), 32'(mon_e.rv1));
            if (mon_e.rv0) chk("p0_rdata", 32'(p0_rdata), 32'(mon_e.rdata));
            if (mon_e.rv1) chk("p1_rdata", 32'(p1_rdata), 32'(mon_e.rdata));
        end
    end

    // stimulus
    logic          a0_act, a1_act, w0, w1, rs;
    logic [AW-1:0] ad0, ad1;
    logic [DW-1:0] d0, d1;

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 3) ^ 16'h5A5A;
            ref_mem[i] = 16'(i * 3) ^ 16'h5A5A;
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        // reset held with a pending port 0 read, then granted right after release
        step(1'b1, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        idle(1'b0);

        // port 1 write then read back
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0200, 16'h1234);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0200, '0);
        idle(1'b0);
        idle(1'b0);

        // continuous contention: bounded wait for port 1
        for (int i = 0; i < 8; i++) begin
            if (last_win == 2 || i == 0) ad1 = 16'(16'h0100 + i);
            step(1'b0, 1'b1, 1'b0, 16'(16'h0020 + i), '0, 1'b1, 1'b0, ad1, '0);
        end
        idle(1'b0);
        idle(1'b0);

        // simultaneous write (port 0) and read (port 1) of the same address
        step(1'b0, 1'b1, 1'b1, 16'h0040, 16'hAAAA, 1'b1, 1'b0, 16'h0040, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0040, '0);
        idle(1'b0);
        idle(1'b0);

        // reset while a port 0 read is in the ISSUE stage
        step(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0011, '0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        idle(1'b0);

        // randomized traffic with occasional resets
        a0_act = 1'b0; a1_act = 1'b0;
        w0 = 1'b0; w1 = 1'b0; ad0 = '0; ad1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 1500; c++) begin
            if (last_win == 1) a0_act = 1'b0;
            if (last_win == 2) a1_act = 1'b0;
            if (!a0_act && $urandom_range(0, 99) < 65) begin
                a0_act = 1'b1;
                w0  = 1'($urandom_range(0, 1));
                ad0 = 16'($urandom_range(0, 31));
                d0  = 16'($urandom);
            end
            if (!a1_act && $urandom_range(0, 99) < 55) begin
                a1_act = 1'b1;
                w1  = 1'($urandom_range(0, 1));
                ad1 = 16'($urandom_range(0, 31));
                d1  = 16'($urandom);
            end
            rs = ($urandom_range(0, 149) == 0);
            step(rs, a0_act, w0, ad0, d0, a1_act, w1, ad1, d1);
        end

        repeat (4) idle(1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
